// File: rtl/pkg_en.sv
// Shared ElectronNest token types and bridge constants.
// Token layouts follow the existing FTk/BTk handshake used across the array.
package pkg_en;

    localparam int WIDTH_DATA   = 32;
    localparam int WIDTH_EXADDR = 16;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic                  c;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic i;
        logic c;
    } BTk_t;

    typedef enum logic [1:0] {
        IDLE,
        BOOT_PAD,
        BOOT_PROG,
        RUN
    } fsm_mbridge_t;

    localparam int BOOT_PAD_DEF = 3;
    localparam int BOOT_LEN_DEF = 5;

endpackage

// File: rtl/en_bram_1r1w.sv
// Simple dual-port BRAM: one registered read port, one write port, read-first.
// Read data only changes when re is high, so a stalled consumer sees it held.
module en_bram_1r1w #(
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int WIDTH          = 32
) (
    input  logic                      clock,
    input  logic                      re,
    input  logic [MEM_DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]          rdata,
    input  logic                      we,
    input  logic [MEM_DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]          wdata
);

    logic [WIDTH-1:0] mem [0:(2**MEM_DEPTH_LOG2)-1];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/en_ext_mem_bridge.sv
// External-memory bridge on the ElectronNest load/store token ports: boot stream, loads, stores.
// Optional macro LDST_FWD_EN forwards same-cycle store data into a load to the same address.
module en_ext_mem_bridge
    import pkg_en::*;
#(
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int BOOT_PAD       = BOOT_PAD_DEF,
    parameter int BOOT_LEN       = BOOT_LEN_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Boot,
    input  logic                    I_Init_We,
    input  logic [WIDTH_EXADDR-1:0] I_Init_Addr,
    input  logic [WIDTH_DATA-1:0]   I_Init_Data,
    input  logic                    I_Ld_Req,
    input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
    output FTk_t                    O_Ld_FTk,
    input  BTk_t                    I_Ld_BTk,
    input  logic                    I_St_Req,
    input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
    input  FTk_t                    I_St_FTk,
    output BTk_t                    O_St_BTk,
    output logic                    O_Busy,
    output logic                    O_Err
);

    localparam int AW = MEM_DEPTH_LOG2;
    localparam int CW = $clog2((BOOT_PAD > BOOT_LEN ? BOOT_PAD : BOOT_LEN) + 1);
    localparam logic [WIDTH_EXADDR:0] MEM_WORDS = (WIDTH_EXADDR+1)'(1 << MEM_DEPTH_LOG2);

    function automatic logic addr_oor(input logic [WIDTH_EXADDR-1:0] a);
        return {1'b0, a} >= MEM_WORDS;
    endfunction

    fsm_mbridge_t                state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        out_v_q, out_v_d, out_a_q, out_a_d, out_bram_q, out_bram_d;
    logic                        skid_v_q, skid_v_d;
    logic [WIDTH_EXADDR-1:0]     skid_addr_q, skid_addr_d, iss_addr;
    logic                        err_q, err_d, st_n_q, st_n_d;
    logic                        adv, st_commit, rd_en, we;
    logic [AW-1:0]               rd_addr, waddr;
    logic [WIDTH_DATA-1:0]       wdata, bram_q, ld_data;
    logic                        unused_bits;

    assign unused_bits = ^{I_Ld_BTk.t, I_Ld_BTk.i, I_Ld_BTk.c,
                           I_St_FTk.a, I_St_FTk.r, I_St_FTk.c, I_Init_Addr};

    en_bram_1r1w #(.MEM_DEPTH_LOG2(MEM_DEPTH_LOG2), .WIDTH(WIDTH_DATA)) u_bram (
        .clock (clock),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (bram_q),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_v_q     <= 1'b0;
            out_a_q     <= 1'b0;
            out_bram_q  <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_addr_q <= '0;
            err_q       <= 1'b0;
            st_n_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_v_q     <= out_v_d;
            out_a_q     <= out_a_d;
            out_bram_q  <= out_bram_d;
            skid_v_q    <= skid_v_d;
            skid_addr_q <= skid_addr_d;
            err_q       <= err_d;
            st_n_q      <= st_n_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_v_d     = out_v_q;
        out_a_d     = out_a_q;
        out_bram_d  = out_bram_q;
        skid_v_d    = skid_v_q;
        skid_addr_d = skid_addr_q;
        err_d       = err_q;
        rd_en       = 1'b0;
        rd_addr     = I_Ld_Addr[AW-1:0];
        adv         = !(out_v_q && I_Ld_BTk.n);
        iss_addr    = skid_v_q ? skid_addr_q : I_Ld_Addr;
        st_commit   = (state_q == RUN) && I_St_Req && I_St_FTk.v && !st_n_q;

        // The parameter BOOT_PAD shadows the state literal, hence the qualified name.
        case (state_q)
            IDLE: begin
                if (I_Boot) begin
                    state_d    = pkg_en::BOOT_PAD;
                    cnt_d      = '0;
                    out_v_d    = 1'b1;
                    out_a_d    = 1'b1;
                    out_bram_d = 1'b0;
                end
            end
            pkg_en::BOOT_PAD: begin
                if (adv) begin
                    out_a_d = 1'b0;
                    if (cnt_q == CW'(BOOT_PAD - 1)) begin
                        state_d    = BOOT_PROG;
                        cnt_d      = '0;
                        rd_en      = 1'b1;
                        rd_addr    = '0;
                        out_bram_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            BOOT_PROG: begin
                if (adv) begin
                    if (cnt_q == CW'(BOOT_LEN - 1)) begin
                        state_d    = RUN;
                        cnt_d      = '0;
                        out_v_d    = 1'b0;
                        out_bram_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = AW'(cnt_q + 1'b1);
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    if (skid_v_q || I_Ld_Req) begin
                        out_v_d    = 1'b1;
                        out_a_d    = 1'b0;
                        out_bram_d = !addr_oor(iss_addr);
                        rd_en      = !addr_oor(iss_addr);
                        rd_addr    = iss_addr[AW-1:0];
                    end else begin
                        out_v_d    = 1'b0;
                        out_bram_d = 1'b0;
                    end
                    if (skid_v_q) begin
                        skid_v_d    = I_Ld_Req;
                        skid_addr_d = I_Ld_Addr;
                    end
                end else if (I_Ld_Req) begin
                    if (!skid_v_q) begin
                        skid_v_d    = 1'b1;
                        skid_addr_d = I_Ld_Addr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (I_Ld_Req && (state_q != RUN || addr_oor(I_Ld_Addr))) err_d = 1'b1;
        if (st_commit && addr_oor(I_St_Addr)) err_d = 1'b1;
        st_n_d = (state_d != RUN);

        if (state_q == IDLE) begin
            we    = I_Init_We;
            waddr = I_Init_Addr[AW-1:0];
            wdata = I_Init_Data;
        end else begin
            we    = st_commit && !addr_oor(I_St_Addr);
            waddr = I_St_Addr[AW-1:0];
            wdata = I_St_FTk.d;
        end
    end

`ifdef LDST_FWD_EN
    // Forwarding at issue time also covers a skid entry: stores committed before its
    // issue are already in the BRAM, and a same-cycle store is caught here.
    logic                  fwd_q;
    logic [WIDTH_DATA-1:0] fwd_data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else if (rd_en) begin
            fwd_q      <= we && (state_q == RUN) && (waddr == rd_addr);
            fwd_data_q <= wdata;
        end
    end

    assign ld_data = !out_bram_q ? '0 : (fwd_q ? fwd_data_q : bram_q);
`else
    assign ld_data = out_bram_q ? bram_q : '0;
`endif

    always_comb begin
        O_Ld_FTk   = '0;
        O_Ld_FTk.v = out_v_q;
        O_Ld_FTk.a = out_a_q;
        O_Ld_FTk.d = ld_data;
        O_St_BTk   = '0;
        O_St_BTk.n = st_n_q;
    end

    assign O_Busy = (state_q == pkg_en::BOOT_PAD) || (state_q == BOOT_PROG);
    assign O_Err  = err_q;

endmodule

// File: tb/tb_en_ext_mem_bridge.sv
// Directed self-checking bench for en_ext_mem_bridge (boot, loads, backpressure, stores, errors).
module tb_en_ext_mem_bridge;
    import pkg_en::*;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    I_Boot, I_Init_We, I_Ld_Req, I_St_Req;
    logic [WIDTH_EXADDR-1:0] I_Init_Addr, I_Ld_Addr, I_St_Addr;
    logic [WIDTH_DATA-1:0]   I_Init_Data;
    FTk_t                    O_Ld_FTk, I_St_FTk;
    BTk_t                    I_Ld_BTk, O_St_BTk;
    logic                    O_Busy, O_Err;

    int n_tests = 0;
    int n_fail  = 0;

    en_ext_mem_bridge #(.MEM_DEPTH_LOG2(10), .BOOT_PAD(3), .BOOT_LEN(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .I_Boot      (I_Boot),
        .I_Init_We   (I_Init_We),
        .I_Init_Addr (I_Init_Addr),
        .I_Init_Data (I_Init_Data),
        .I_Ld_Req    (I_Ld_Req),
        .I_Ld_Addr   (I_Ld_Addr),
        .O_Ld_FTk    (O_Ld_FTk),
        .I_Ld_BTk    (I_Ld_BTk),
        .I_St_Req    (I_St_Req),
        .I_St_Addr   (I_St_Addr),
        .I_St_FTk    (I_St_FTk),
        .O_St_BTk    (O_St_BTk),
        .O_Busy      (O_Busy),
        .O_Err       (O_Err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic FTk_t mk(input logic v, input logic a, input logic [WIDTH_DATA-1:0] d);
        FTk_t t;
        t   = '0;
        t.v = v;
        t.a = a;
        t.d = d;
        return t;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic init_wr(input logic [WIDTH_EXADDR-1:0] a, input logic [WIDTH_DATA-1:0] d);
        I_Init_We = 1'b1; I_Init_Addr = a; I_Init_Data = d;
        tick();
        I_Init_We = 1'b0;
    endtask

    task automatic load(input logic [WIDTH_EXADDR-1:0] a, input logic [WIDTH_DATA-1:0] exp, input string tag);
        I_Ld_Req = 1'b1; I_Ld_Addr = a;
        tick();
        I_Ld_Req = 1'b0;
        chk(tag, O_Ld_FTk, mk(1'b1, 1'b0, exp));
        tick();
    endtask

    task automatic store(input logic [WIDTH_EXADDR-1:0] a, input logic [WIDTH_DATA-1:0] d);
        I_St_Req = 1'b1; I_St_Addr = a; I_St_FTk = mk(1'b1, 1'b0, d);
        tick();
        I_St_Req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ldftk"}, O_Ld_FTk, '0);
        chk({tag, "_stbtk"}, O_St_BTk, '0);
        chk({tag, "_busy"}, O_Busy, 1'b0);
        chk({tag, "_err"}, O_Err, 1'b0);
    endtask

    // Pulses I_Boot and checks the first n boot words; a store is attempted on word 1.
    task automatic run_boot(input int n);
        logic [WIDTH_DATA-1:0] exp_d [8];
        exp_d = '{32'h0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        I_Boot = 1'b1;
        tick();
        I_Boot = 1'b0;
        I_St_Addr = 16'h30; I_St_FTk = mk(1'b1, 1'b0, 32'hDEAD);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("boot_w%0d", i), O_Ld_FTk, mk(1'b1, i == 0, exp_d[i]));
            chk($sformatf("boot_busy%0d", i), O_Busy, 1'b1);
            chk($sformatf("boot_stn%0d", i), O_St_BTk.n, 1'b1);
            I_St_Req = (i == 1);
            tick();
        end
        I_St_Req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; I_Boot = 1'b0; I_Init_We = 1'b0; I_Ld_Req = 1'b0; I_St_Req = 1'b0;
        I_Init_Addr = '0; I_Init_Data = '0; I_Ld_Addr = '0; I_St_Addr = '0;
        I_St_FTk = '0; I_Ld_BTk = '0;
        #1;
        check_zero("rst");
        tick(); tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) init_wr(16'(i), 32'h11 * (i + 1));
        init_wr(16'h20, 32'hCAFE);
        init_wr(16'h10, 32'h1010);
        init_wr(16'h11, 32'h1111);
        init_wr(16'h30, 32'h3030);
        init_wr(16'h40, 32'h1);
        chk("idle_busy", O_Busy, 1'b0);

        run_boot(8);
        chk("post_boot_v", O_Ld_FTk.v, 1'b0);
        chk("post_boot_busy", O_Busy, 1'b0);
        chk("run_stbtk", O_St_BTk, '0);

        I_Ld_Req = 1'b1; I_Ld_Addr = 16'h20;
        tick();
        I_Ld_Req = 1'b0;
        chk("lat_t1", O_Ld_FTk, mk(1'b1, 1'b0, 32'hCAFE));
        tick();
        chk("lat_t2_v", O_Ld_FTk.v, 1'b0);

        load(16'h30, 32'h3030, "boot_store_dropped");
        store(16'h30, 32'hBEEF);
        load(16'h30, 32'hBEEF, "store_load");

        I_St_Req = 1'b1; I_St_Addr = 16'h40; I_St_FTk = mk(1'b1, 1'b0, 32'h5);
        I_Ld_Req = 1'b1; I_Ld_Addr = 16'h40;
        tick();
        I_St_Req = 1'b0; I_Ld_Req = 1'b0;
`ifdef LDST_FWD_EN
        chk("hazard", O_Ld_FTk, mk(1'b1, 1'b0, 32'h5));
`else
        chk("hazard", O_Ld_FTk, mk(1'b1, 1'b0, 32'h1));
`endif
        tick();
        load(16'h40, 32'h5, "hazard_after");

        I_Ld_Req = 1'b1; I_Ld_Addr = 16'h10;
        tick();
        chk("bp_h1", O_Ld_FTk, mk(1'b1, 1'b0, 32'h1010));
        I_Ld_Addr = 16'h11; I_Ld_BTk.n = 1'b1;
        tick();
        chk("bp_h2", O_Ld_FTk, mk(1'b1, 1'b0, 32'h1010));
        chk("bp_err0", O_Err, 1'b0);
        I_Ld_Addr = 16'h12;
        tick();
        chk("bp_h3", O_Ld_FTk, mk(1'b1, 1'b0, 32'h1010));
        chk("bp_err1", O_Err, 1'b1);
        I_Ld_Req = 1'b0;
        tick();
        chk("bp_h4", O_Ld_FTk, mk(1'b1, 1'b0, 32'h1010));
        I_Ld_BTk.n = 1'b0;
        tick();
        chk("bp_skid", O_Ld_FTk, mk(1'b1, 1'b0, 32'h1111));
        tick();
        chk("bp_idle_v", O_Ld_FTk.v, 1'b0);

        reset = 1'b0;
        #1;
        check_zero("rst2");
        tick();
        reset = 1'b1;
        tick();
        run_boot(4);
        chk("mid_w4", O_Ld_FTk, mk(1'b1, 1'b0, 32'h22));
        reset = 1'b0;
        #1;
        check_zero("rst_mid");
        tick();
        reset = 1'b1;
        tick();
        chk("mid_idle_busy", O_Busy, 1'b0);
        run_boot(8);
        chk("replay_done_busy", O_Busy, 1'b0);
        chk("replay_err", O_Err, 1'b0);

        load(16'h400, 32'h0, "oor_load");
        chk("oor_load_err", O_Err, 1'b1);
        store(16'h430, 32'h9999);
        load(16'h30, 32'hBEEF, "oor_store_dropped");

        reset = 1'b0;
        #1;
        chk("rst3_err", O_Err, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        I_Ld_Req = 1'b1; I_Ld_Addr = 16'h20;
        tick();
        I_Ld_Req = 1'b0;
        chk("idle_ld_v", O_Ld_FTk.v, 1'b0);
        chk("idle_ld_err", O_Err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
